wash_program_sequencer: RTL and testbench
=========================================

# wash_program_sequencer

Programmable cycle sequencer for the washing-machine datapath. It sequences fill, wash, drain, rinse and spin valves and motor using internal phase timers and sensor handshakes. It replaces externally driven cycle and spin timeout strobes with on-chip counters. It adds sensor timeouts, a fault state and a user abort path.

## Interface
- `CNT_W`, 8: width of the phase time registers (cycles).
- `TMO`, 64: maximum cycles allowed in any fill or drain state before fault.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: request to run; also acknowledges completion.
- `doorclose` in 1: door-closed sensor.
- `filled` in 1: water-level-full sensor.
- `drained` in 1: drum-empty sensor.
- `abort` in 1: user abort; level-sensitive.
- `wash_time` in CNT_W: wash phase length, in cycles.
- `rinse_time` in CNT_W: length of each rinse phase, in cycles.
- `spin_time` in CNT_W: spin phase length, in cycles.
- `rinse_count` in 2: number of rinse passes, 0 to 3.
- `doorlock`, `fillvalve_on`, `drainvalve_on`, `motor_on` out 1: actuators.
- `soap_wash`, `water_wash` out 1: phase indicators.
- `done` out 1: program complete.
- `fault` out 1: sensor timeout occurred.
- `state_o` out 4: current state encoding, for debug.

## Operation
- States: IDLE, FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, SPIN, DONE, ABORT_DRAIN, FAULT.
- Moore outputs (1 in listed states, 0 elsewhere):
  - `doorlock`: every state except IDLE, DONE and FAULT.
  - `fillvalve_on`: FILL_W, FILL_R.
  - `motor_on`: WASH, RINSE, SPIN.
  - `soap_wash`: WASH.
  - `water_wash`: RINSE.
  - `drainvalve_on`: DRAIN_W, DRAIN_R, SPIN, ABORT_DRAIN, FAULT.
  - `done`: DONE.
  - `fault`: FAULT.
- IDLE → FILL_W when `start && doorclose`. On this transition, latch `wash_time`, `rinse_time`, `spin_time` and `rinse_count`. `start` without `doorclose` is ignored.
- FILL_W → WASH on `filled`. FILL_R → RINSE on `filled`.
- WASH → DRAIN_W after the latched wash time expires. RINSE → DRAIN_R after the latched rinse time expires.
- DRAIN_W on `drained`:
  - → FILL_R if remaining rinses > 0.
  - → SPIN otherwise.
- DRAIN_R on `drained`: decrement remaining rinses.
  - → FILL_R if the decremented value > 0.
  - → SPIN otherwise.
- SPIN → DONE after the latched spin time expires.
- DONE holds while `start` = 1, then → IDLE when `start` = 0.
- `abort` = 1 in any state from FILL_W through SPIN → ABORT_DRAIN. ABORT_DRAIN → IDLE on `drained`. `abort` is ignored in IDLE, DONE, ABORT_DRAIN and FAULT.
- Timeout: in FILL_W, FILL_R, DRAIN_W, DRAIN_R or ABORT_DRAIN, if the sensor is not seen by the TMO-th cycle in the state → FAULT.
- FAULT is sticky; only `rst` exits it.
- Priority: `rst` > `abort` > sensor > timeout. A sensor and the timeout in the same cycle take the sensor transition.
- Phase timer arithmetic:
  - Loaded with the latched value on state entry; a value of 0 is treated as 1.
  - The phase lasts exactly max(N,1) cycles, counting the entry cycle.
  - Decrements by 1 per cycle; exit is taken on the edge after the cycle where the count = 1.
- Timeout counter: CNT width clog2(TMO+1). Cleared on every state change; saturates, never wraps.

## Timing
- Reset (`rst` = 0 at a rising edge): state = IDLE, all outputs 0, counters and latched parameters 0, `state_o` = 0.
- Outputs decode directly from the state register, so an output change appears in the cycle after the causing input is sampled.
- Sensor inputs are sampled once per cycle; no internal synchronizers (the system integrator provides them).
- Reset mid-operation: the next edge forces IDLE with all valves and motor off. No drain is performed.
- Parameter inputs may change freely after the start latch without effect.

## Structure
- Package `wash_pkg`:
  - state enum with fixed 4-bit encoding, IDLE = 0;
  - output-decode function;
  - default `TMO` constant.
- Sub-module `wash_phase_timer`: loadable down-counter with `load`, `value`, `expire`, min-1 clamp. One instance is shared by WASH, RINSE and SPIN; these states are never concurrent.
- Timeout counter and rinse counter are inline.

## Test plan
- **Nominal program.** Stimulus: `wash_time` = 4, `rinse_count` = 1, `rinse_time` = 3, `spin_time` = 5; each sensor asserted 2 cycles after its state is entered. Required: sequence IDLE→FILL_W→WASH→DRAIN_W→FILL_R→RINSE→DRAIN_R→SPIN→DONE; `soap_wash` high exactly 4 cycles, `water_wash` exactly 3, SPIN exactly 5; `done` = 1 until `start` drops.
- **No rinse, zero time.** Stimulus: `rinse_count` = 0, `wash_time` = 0. Required: WASH lasts 1 cycle; DRAIN_W → SPIN directly; `water_wash` never 1.
- **Fill timeout.** Stimulus: `TMO` = 16, `filled` never asserted. Required: FILL_W lasts 16 cycles, then `fault` = 1, `drainvalve_on` = 1, `doorlock` = 0; `start` and `abort` have no effect; exit only via `rst`.
- **Abort during WASH.** Stimulus: `abort` pulse in cycle 2 of WASH. Required: next cycle ABORT_DRAIN, `motor_on` = 0, `drainvalve_on` = 1; `drained` → IDLE; `done` never 1.
- **Start gating and tie-break.** Stimulus: `start` with `doorclose` = 0. Required: stays in IDLE. Stimulus: `filled` asserted on exactly the 16th FILL_W cycle. Required: WASH entered, not FAULT.
- **Reset mid-SPIN.** Stimulus: `rst` = 0 in cycle 3 of SPIN. Required: next edge all outputs 0, `state_o` = 0.

Source files
------------

// File: rtl/wash_program_sequencer_pkg.sv
//============================================================================
// Module      : wash_pkg
// Description : Shared state encoding, Moore output decode and defaults for
//               the wash program sequencer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package wash_pkg;

    localparam int c_tmo_default = 64;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FILL_W      = 4'd1,
        WASH        = 4'd2,
        DRAIN_W     = 4'd3,
        FILL_R      = 4'd4,
        RINSE       = 4'd5,
        DRAIN_R     = 4'd6,
        SPIN        = 4'd7,
        DONE        = 4'd8,
        ABORT_DRAIN = 4'd9,
        FAULT       = 4'd10
    } state_t;

    typedef struct packed {
        logic doorlock;
        logic fillvalve_on;
        logic drainvalve_on;
        logic motor_on;
        logic soap_wash;
        logic water_wash;
        logic done;
        logic fault;
    } outs_t;

    function automatic outs_t decode_outputs(state_t s);
        outs_t o;
        o = '0;
        case (s)
            FILL_W, FILL_R: begin
                o.doorlock     = 1'b1;
                o.fillvalve_on = 1'b1;
            end
            WASH: begin
                o.doorlock  = 1'b1;
                o.motor_on  = 1'b1;
                o.soap_wash = 1'b1;
            end
            RINSE: begin
                o.doorlock   = 1'b1;
                o.motor_on   = 1'b1;
                o.water_wash = 1'b1;
            end
            DRAIN_W, DRAIN_R, ABORT_DRAIN: begin
                o.doorlock      = 1'b1;
                o.drainvalve_on = 1'b1;
            end
            SPIN: begin
                o.doorlock      = 1'b1;
                o.drainvalve_on = 1'b1;
                o.motor_on      = 1'b1;
            end
            DONE:  o.done = 1'b1;
            // The drum stays unlocked in FAULT but keeps draining.
            FAULT: begin
                o.drainvalve_on = 1'b1;
                o.fault         = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wash_program_sequencer_if.sv
//============================================================================
// Module      : wash_program_sequencer_if
// Description : Sensor/command inputs and actuator/status outputs of the
//               wash program sequencer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface wash_program_sequencer_if;

    logic       start;
    logic       doorclose;
    logic       filled;
    logic       drained;
    logic       abort;
    logic       doorlock;
    logic       fillvalve_on;
    logic       drainvalve_on;
    logic       motor_on;
    logic       soap_wash;
    logic       water_wash;
    logic       done;
    logic       fault;
    logic [3:0] state_o;

    modport master (
        output start, doorclose, filled, drained, abort,
        input  doorlock, fillvalve_on, drainvalve_on, motor_on,
               soap_wash, water_wash, done, fault, state_o
    );

    modport slave (
        input  start, doorclose, filled, drained, abort,
        output doorlock, fillvalve_on, drainvalve_on, motor_on,
               soap_wash, water_wash, done, fault, state_o
    );

endinterface

`default_nettype wire

// File: rtl/wash_program_sequencer_phase_timer.sv
//============================================================================
// Module      : wash_phase_timer
// Description : Loadable down-counter timing the WASH, RINSE and SPIN phases.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module wash_phase_timer #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         load,
    input  wire logic [W-1:0] value,
    output logic              expire
);

    logic [W-1:0] r_count;

    // A zero length is clamped to one so every phase occupies its entry cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= (value == '0) ? W'(1) : value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign expire = (r_count == W'(1));

endmodule

`default_nettype wire

// File: rtl/wash_program_sequencer.sv
//============================================================================
// Module      : wash_program_sequencer
// Description : Fill/wash/drain/rinse/spin cycle sequencer with on-chip phase
//               timers, sensor timeouts, sticky fault and user abort.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module wash_program_sequencer
    import wash_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int TMO   = c_tmo_default
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    wash_program_sequencer_if.slave    bus,
    input  wire logic [CNT_W-1:0]      wash_time,
    input  wire logic [CNT_W-1:0]      rinse_time,
    input  wire logic [CNT_W-1:0]      spin_time,
    input  wire logic [1:0]            rinse_count
);

    localparam int c_tmo_w = $clog2(TMO + 1);

    state_t             r_state;
    state_t             w_next;
    outs_t              w_outs;
    logic [CNT_W-1:0]   r_wash_time;
    logic [CNT_W-1:0]   r_rinse_time;
    logic [CNT_W-1:0]   r_spin_time;
    logic [1:0]         r_rinse_left;
    logic [c_tmo_w-1:0] r_tmo;
    logic               w_tmo_hit;
    logic               w_rinse_dec;
    logic               w_phase_load;
    logic [CNT_W-1:0]   w_phase_value;
    logic               w_phase_expire;

    // r_tmo is 0 in the entry cycle, so TMO-1 marks the last allowed cycle.
    assign w_tmo_hit = (r_tmo >= c_tmo_w'(TMO - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rinse_dec = 1'b0;
        w_outs      = decode_outputs(r_state);
        case (r_state)
            IDLE: begin
                if (bus.start && bus.doorclose) w_next = FILL_W;
            end
            FILL_W: begin
                if (bus.abort)       w_next = ABORT_DRAIN;
                else if (bus.filled) w_next = WASH;
                else if (w_tmo_hit)  w_next = FAULT;
            end
            WASH: begin
                if (bus.abort)           w_next = ABORT_DRAIN;
                else if (w_phase_expire) w_next = DRAIN_W;
            end
            DRAIN_W: begin
                if (bus.abort)        w_next = ABORT_DRAIN;
                else if (bus.drained) w_next = (r_rinse_left != 2'd0) ? FILL_R : SPIN;
                else if (w_tmo_hit)   w_next = FAULT;
            end
            FILL_R: begin
                if (bus.abort)       w_next = ABORT_DRAIN;
                else if (bus.filled) w_next = RINSE;
                else if (w_tmo_hit)  w_next = FAULT;
            end
            RINSE: begin
                if (bus.abort)           w_next = ABORT_DRAIN;
                else if (w_phase_expire) w_next = DRAIN_R;
            end
            DRAIN_R: begin
                if (bus.abort) begin
                    w_next = ABORT_DRAIN;
                end else if (bus.drained) begin
                    w_rinse_dec = 1'b1;
                    w_next      = (r_rinse_left > 2'd1) ? FILL_R : SPIN;
                end else if (w_tmo_hit) begin
                    w_next = FAULT;
                end
            end
            SPIN: begin
                if (bus.abort)           w_next = ABORT_DRAIN;
                else if (w_phase_expire) w_next = DONE;
            end
            DONE: begin
                if (!bus.start) w_next = IDLE;
            end
            ABORT_DRAIN: begin
                if (bus.drained)    w_next = IDLE;
                else if (w_tmo_hit) w_next = FAULT;
            end
            FAULT:   w_next = FAULT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wash_time  <= '0;
            r_rinse_time <= '0;
            r_spin_time  <= '0;
            r_rinse_left <= '0;
            r_tmo        <= '0;
        end else begin
            if (r_state == IDLE && w_next == FILL_W) begin
                r_wash_time  <= wash_time;
                r_rinse_time <= rinse_time;
                r_spin_time  <= spin_time;
                r_rinse_left <= rinse_count;
            end else if (w_rinse_dec) begin
                r_rinse_left <= r_rinse_left - 2'd1;
            end
            if (w_next != r_state) begin
                r_tmo <= '0;
            end else if (r_tmo != c_tmo_w'(TMO)) begin
                r_tmo <= r_tmo + c_tmo_w'(1);
            end
        end
    end

    // The single phase timer is reloaded on entry to each timed state.
    always_comb begin
        w_phase_load  = (w_next != r_state) &&
                        (w_next == WASH || w_next == RINSE || w_next == SPIN);
        w_phase_value = r_spin_time;
        case (w_next)
            WASH:    w_phase_value = r_wash_time;
            RINSE:   w_phase_value = r_rinse_time;
            default: w_phase_value = r_spin_time;
        endcase
    end

    wash_phase_timer #(
        .W      (CNT_W)
    ) u_phase_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_phase_load),
        .value  (w_phase_value),
        .expire (w_phase_expire)
    );

    assign bus.doorlock      = w_outs.doorlock;
    assign bus.fillvalve_on  = w_outs.fillvalve_on;
    assign bus.drainvalve_on = w_outs.drainvalve_on;
    assign bus.motor_on      = w_outs.motor_on;
    assign bus.soap_wash     = w_outs.soap_wash;
    assign bus.water_wash    = w_outs.water_wash;
    assign bus.done          = w_outs.done;
    assign bus.fault         = w_outs.fault;
    assign bus.state_o       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_wash_program_sequencer.sv
//============================================================================
// Module      : tb_wash_program_sequencer
// Description : Scoreboard bench: expected state/duration sequences are
//               queued per program and compared on every state change.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_wash_program_sequencer;
    import wash_pkg::*;

    localparam int CNT_W = 8;
    localparam int TMO   = 16;

    typedef struct {
        state_t st;
        int     dur;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] wash_time, rinse_time, spin_time;
    logic [1:0]       rinse_count;

    wash_program_sequencer_if bus();

    wash_program_sequencer #(
        .CNT_W       (CNT_W),
        .TMO         (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .wash_time   (wash_time),
        .rinse_time  (rinse_time),
        .spin_time   (spin_time),
        .rinse_count (rinse_count)
    );

    always #5 clk = ~clk;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    state_t prev_st;
    int     cnt;
    int     exp_dur;
    int     fill_dly, drain_dly, done_hold;
    bit     keep_start;
    state_t rst_st, abort_st;
    int     rst_cnt, abort_cnt;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Actuator table: {doorlock, fill, drain, motor, soap, water, done, fault}
    function automatic logic [7:0] exp_outs(input state_t s);
        case (s)
            FILL_W, FILL_R:               return 8'b1100_0000;
            WASH:                         return 8'b1001_1000;
            RINSE:                        return 8'b1001_0100;
            DRAIN_W, DRAIN_R, ABORT_DRAIN: return 8'b1010_0000;
            SPIN:                         return 8'b1011_0000;
            DONE:                         return 8'b0000_0010;
            FAULT:                        return 8'b0010_0001;
            default:                      return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [7:0] dut_outs();
        return {bus.doorlock, bus.fillvalve_on, bus.drainvalve_on, bus.motor_on,
                bus.soap_wash, bus.water_wash, bus.done, bus.fault};
    endfunction

    task automatic push(input state_t s, input int d);
        exp_t e;
        e.st  = s;
        e.dur = d;
        exp_q.push_back(e);
    endtask

    // One clock: sample just after the edge, score any state change, then
    // drive the sensors/commands the environment would present next cycle.
    task automatic tick();
        state_t cur;
        exp_t   e;
        @(posedge clk);
        #1;
        cur = state_t'(bus.state_o);
        if (cur != prev_st) begin
            if (exp_dur != 0)
                chk($sformatf("dur_%s", prev_st.name()), cnt, exp_dur);
            if (exp_q.size() == 0) begin
                chk("unexpected_state", int'(bus.state_o), 15);
                exp_dur = 0;
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("state_to_%s", e.st.name()), int'(bus.state_o), int'(e.st));
                chk($sformatf("outs_in_%s", e.st.name()), int'(dut_outs()), int'(exp_outs(e.st)));
                exp_dur = e.dur;
            end
            cnt     = 1;
            prev_st = cur;
        end else begin
            cnt++;
        end

        rst       = 1'b1;
        bus.abort = 1'b0;
        if (rst_cnt != 0 && cur == rst_st && cnt == rst_cnt) begin
            rst       = 1'b0;
            bus.start = 1'b0;
        end
        if (abort_cnt != 0 && cur == abort_st && cnt == abort_cnt)
            bus.abort = 1'b1;
        bus.filled  = (cur == FILL_W || cur == FILL_R) && fill_dly > 0 && cnt >= fill_dly;
        bus.drained = (cur == DRAIN_W || cur == DRAIN_R || cur == ABORT_DRAIN) &&
                      drain_dly > 0 && cnt >= drain_dly;
        if (cur != IDLE && cur != DONE && !keep_start) bus.start = 1'b0;
        if (cur == DONE && cnt >= done_hold)           bus.start = 1'b0;
        if (cur != IDLE) begin
            wash_time   = CNT_W'($urandom_range(0, 255));
            rinse_time  = CNT_W'($urandom_range(0, 255));
            spin_time   = CNT_W'($urandom_range(0, 255));
            rinse_count = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic setup(input int wt, input int rc, input int rt, input int st,
                         input int fd, input int dd, input bit ks);
        wash_time   = CNT_W'(wt);
        rinse_count = 2'(rc);
        rinse_time  = CNT_W'(rt);
        spin_time   = CNT_W'(st);
        fill_dly    = fd;
        drain_dly   = dd;
        keep_start  = ks;
        done_hold   = 3;
        rst_cnt     = 0;
        abort_cnt   = 0;
        rst_st      = IDLE;
        abort_st    = IDLE;
    endtask

    task automatic run(input string name, input int n);
        bus.start     = 1'b1;
        bus.doorclose = 1'b1;
        repeat (n) tick();
        chk({name, "_sb_left"}, exp_q.size(), 0);
        chk({name, "_end_idle"}, int'(bus.state_o), int'(IDLE));
        exp_q.delete();
    endtask

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.doorclose = 1'b1;
        bus.filled    = 1'b0;
        bus.drained   = 1'b0;
        bus.abort     = 1'b0;
        setup(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(bus.state_o), 0);
        chk("reset_outs", int'(dut_outs()), 0);
        prev_st = IDLE;
        cnt     = 1;
        exp_dur = 0;
        rst     = 1'b1;

        // Nominal program with one rinse pass.
        setup(4, 1, 3, 5, 3, 3, 1'b1);
        push(FILL_W, 3); push(WASH, 4); push(DRAIN_W, 3); push(FILL_R, 3);
        push(RINSE, 3); push(DRAIN_R, 3); push(SPIN, 5); push(DONE, 3); push(IDLE, 0);
        run("nominal", 40);

        // No rinse and a zero wash time.
        setup(0, 0, 7, 2, 3, 3, 1'b1);
        push(FILL_W, 3); push(WASH, 1); push(DRAIN_W, 3); push(SPIN, 2);
        push(DONE, 3); push(IDLE, 0);
        run("no_rinse", 25);

        // Fill timeout; start held and abort pulsed inside FAULT.
        setup(4, 1, 3, 5, 0, 3, 1'b1);
        abort_st = FAULT; abort_cnt = 4;
        rst_st   = FAULT; rst_cnt   = 10;
        push(FILL_W, TMO); push(FAULT, 10); push(IDLE, 0);
        run("fill_timeout", 35);

        // Abort in the second WASH cycle.
        setup(6, 2, 3, 5, 3, 3, 1'b0);
        abort_st = WASH; abort_cnt = 2;
        push(FILL_W, 3); push(WASH, 2); push(ABORT_DRAIN, 3); push(IDLE, 0);
        run("abort_wash", 20);

        // Start without a closed door is ignored.
        setup(4, 1, 3, 5, 3, 3, 1'b0);
        bus.doorclose = 1'b0;
        bus.start     = 1'b1;
        repeat (5) tick();
        chk("gate_idle", int'(bus.state_o), int'(IDLE));
        chk("gate_sb_left", exp_q.size(), 0);
        bus.start = 1'b0;

        // Fill seen on the last allowed cycle wins over the timeout.
        setup(2, 0, 3, 1, TMO, 3, 1'b0);
        push(FILL_W, TMO); push(WASH, 2); push(DRAIN_W, 3); push(SPIN, 1);
        push(DONE, 1); push(IDLE, 0);
        run("tie_break", 35);

        // Two rinse passes, then reset in the third SPIN cycle.
        setup(1, 2, 1, 8, 3, 3, 1'b0);
        rst_st = SPIN; rst_cnt = 3;
        push(FILL_W, 3); push(WASH, 1); push(DRAIN_W, 3);
        push(FILL_R, 3); push(RINSE, 1); push(DRAIN_R, 3);
        push(FILL_R, 3); push(RINSE, 1); push(DRAIN_R, 3);
        push(SPIN, 3); push(IDLE, 0);
        run("reset_spin", 35);
        chk("post_reset_outs", int'(dut_outs()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
